// File: rtl/core_pkg.sv
// Shared types for the output packer. Entries are sized for the widest
// supported bus so a single struct definition serves every configuration.
package core_pkg;

   localparam int MAX_GBUS_DATA = 256;
   localparam int MAX_LANES     = 32;

   typedef logic [MAX_LANES-1:0] lane_mask_t;

   typedef struct packed {
      logic [MAX_GBUS_DATA-1:0] data;
      lane_mask_t               mask;
   } opack_entry_t;

   function automatic int calc_lanes(input int gbus_data, input int idata_bit);
      return gbus_data / idata_bit;
   endfunction

   // Mask with the low n lanes set.
   function automatic lane_mask_t ones_mask(input int n);
      lane_mask_t m;
      m = '0;
      for (int i = 0; i < MAX_LANES; i++) begin
         if (i < n) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/core_opack_fifo.sv
// Synchronous FIFO of packed entries; a push while full is taken only when a
// pop frees the head slot on the same edge.
module core_opack_fifo
   import core_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  opack_entry_t push_entry,
   input  logic         pop,
   output opack_entry_t head_entry,
   output logic         full,
   output logic         empty
);

   localparam int PTR_W = $clog2(DEPTH);

   opack_entry_t     mem_q [DEPTH];
   logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   assign empty      = (wr_ptr_q == rd_ptr_q);
   assign full       = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign head_entry = mem_q[rd_ptr_q[PTR_W-1:0]];

   always_comb begin
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset; pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_entry;
   end

endmodule

// File: rtl/core_opack.sv
// Output packer: gathers quantized results into bus words, queues them, and
// gives a memory readback skid priority over packed words on the gbus channel.
module core_opack
   import core_pkg::*;
#(
   parameter int IDATA_BIT  = 8,
   parameter int GBUS_DATA  = 64,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [IDATA_BIT-1:0]           idata,
   input  logic                           idata_valid,
   output logic                           idata_ready,
   input  logic                           cfg_flush,
   input  logic                           cfg_kv_wr,
   input  logic [GBUS_DATA-1:0]           mem_rdata,
   input  logic                           mem_rvalid,
   output logic [GBUS_DATA-1:0]           gbus_rdata,
   output logic [GBUS_DATA/IDATA_BIT-1:0] gbus_rmask,
   output logic                           gbus_rvalid,
   input  logic                           gbus_rready,
   output logic [GBUS_DATA-1:0]           cmem_wdata,
   output logic [GBUS_DATA/IDATA_BIT-1:0] cmem_wmask,
   output logic                           cmem_wen,
   output logic                           ovf_err,
   output logic [15:0]                    word_cnt
);

   localparam int         LANES     = calc_lanes(GBUS_DATA, IDATA_BIT);
   localparam int         LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
   localparam lane_mask_t FULL_MASK = ones_mask(LANES);

   typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

   logic [LANE_W-1:0] lane_q, lane_d;
   opack_entry_t      pack_q, pack_d, merged;
   opack_entry_t      skid_q, skid_d;
   logic              skid_valid_q, skid_valid_d;
   out_state_t        out_state_q, out_state_d;
   opack_entry_t      out_q, out_d;
   logic              out_from_fifo_q, out_from_fifo_d;
   logic              ovf_q, ovf_d;
   logic [15:0]       word_cnt_q, word_cnt_d;

   logic              accept, word_push, flush_req, flush_ok;
   logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic              can_load, handshake, mem_drop;
   logic [31:0]       lane_shift;
   opack_entry_t      fifo_head;
   logic              unused_out_bits;

   assign idata_ready = !fifo_full;
   assign accept      = idata_valid && idata_ready;
   assign handshake   = (out_state_q == OUT_FULL) && gbus_rready;
   assign can_load    = (out_state_q == OUT_EMPTY) || gbus_rready;
   assign fifo_pop    = can_load && !skid_valid_q && !fifo_empty;
   assign lane_shift  = 32'(lane_q) * 32'(IDATA_BIT);

   // The incoming byte is merged before any push so a flush or word
   // completion in the same cycle carries it; a flush that finds the FIFO
   // full keeps the partial word and flags overflow.
   always_comb begin
      merged = pack_q;
      if (accept) begin
         merged.data = pack_q.data | (MAX_GBUS_DATA'(idata) << lane_shift);
         merged.mask = pack_q.mask | (lane_mask_t'(1) << lane_q);
      end
      word_push = accept && (lane_q == LANE_W'(LANES - 1));
      flush_req = cfg_flush && !word_push && ((lane_q != '0) || accept);
      flush_ok  = !fifo_full || fifo_pop;
      fifo_push = word_push || (flush_req && flush_ok);
      lane_d    = lane_q;
      pack_d    = pack_q;
      if (fifo_push) begin
         lane_d = '0;
         pack_d = '0;
      end else if (accept) begin
         lane_d = lane_q + LANE_W'(1);
         pack_d = merged;
      end
   end

   core_opack_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (fifo_push),
      .push_entry (merged),
      .pop        (fifo_pop),
      .head_entry (fifo_head),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

   // Output stage reloads whenever it is empty or being drained, skid first.
   always_comb begin
      out_state_d     = out_state_q;
      out_d           = out_q;
      out_from_fifo_d = out_from_fifo_q;
      skid_d          = skid_q;
      skid_valid_d    = skid_valid_q;
      if (can_load) begin
         if (skid_valid_q) begin
            out_d           = skid_q;
            out_state_d     = OUT_FULL;
            out_from_fifo_d = 1'b0;
            skid_valid_d    = 1'b0;
         end else if (!fifo_empty) begin
            out_d           = fifo_head;
            out_state_d     = OUT_FULL;
            out_from_fifo_d = 1'b1;
         end else begin
            out_state_d     = OUT_EMPTY;
         end
      end
      if (!skid_valid_q && mem_rvalid) begin
         skid_valid_d = 1'b1;
         skid_d.data  = MAX_GBUS_DATA'(mem_rdata);
         skid_d.mask  = FULL_MASK;
      end
      mem_drop   = skid_valid_q && mem_rvalid;
      word_cnt_d = word_cnt_q + ((handshake && out_from_fifo_q) ? 16'd1 : 16'd0);
      ovf_d      = ovf_q | (idata_valid && !idata_ready) | mem_drop |
                   (flush_req && !flush_ok);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane_q          <= '0;
         pack_q          <= '0;
         skid_q          <= '0;
         skid_valid_q    <= 1'b0;
         out_state_q     <= OUT_EMPTY;
         out_q           <= '0;
         out_from_fifo_q <= 1'b0;
         ovf_q           <= 1'b0;
         word_cnt_q      <= '0;
      end else begin
         lane_q          <= lane_d;
         pack_q          <= pack_d;
         skid_q          <= skid_d;
         skid_valid_q    <= skid_valid_d;
         out_state_q     <= out_state_d;
         out_q           <= out_d;
         out_from_fifo_q <= out_from_fifo_d;
         ovf_q           <= ovf_d;
         word_cnt_q      <= word_cnt_d;
      end
   end

   assign gbus_rvalid = (out_state_q == OUT_FULL);
   assign gbus_rdata  = out_q.data[GBUS_DATA-1:0];
   assign gbus_rmask  = out_q.mask[LANES-1:0];
   assign cmem_wen    = handshake && out_from_fifo_q && cfg_kv_wr;
   assign cmem_wdata  = gbus_rdata;
   assign cmem_wmask  = gbus_rmask;
   assign ovf_err     = ovf_q;
   assign word_cnt    = word_cnt_q;

   // Entry bits above the configured bus width are always zero.
   assign unused_out_bits = ^out_q;

endmodule
